// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: register-file writeback controller.
//   Merges execute results (direct path) and load results (small FIFO) into the
//   single registered write port of the GPR file, and keeps a pending-write scoreboard.
//   Latency: ex accepted at edge N -> write visible N..N+1; load pushed into an empty
//   FIFO at edge N -> written from edge N+1 at the earliest.
//   Backpressure: ex_ready_o = ld_ready_o = !FIFO full (independent of any valid input).
// Ports: clk/rst_n (async, active-low); ex_* execute result handshake; ld_* load
//   handshake; reserve_i/reserve_idx_i scoreboard set; busy_o scoreboard;
//   reg_w_idx_o/wdata_o/wen_o/wr_scope_o register-file write port.
// Optional macro WB_BYPASS_EN: adds combinational read-bypass ports a/b
//   (ra_index_i, rvalue_a_i, rvalue_a_o, rb_index_i, rvalue_b_i, rvalue_b_o).
module reg_wb_ctrl #(
   parameter int NREGS     = 16,
   parameter int IDXW      = 4,
   parameter int LDQ_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid_i,
   output logic             ex_ready_o,
   input  logic [IDXW-1:0]  ex_idx_i,
   input  logic [31:0]      ex_data_i,
   input  logic [1:0]       ex_scope_i,
   input  logic             ld_valid_i,
   output logic             ld_ready_o,
   input  logic [IDXW-1:0]  ld_idx_i,
   input  logic [31:0]      ld_data_i,
   input  logic [1:0]       ld_scope_i,
   input  logic             reserve_i,
   input  logic [IDXW-1:0]  reserve_idx_i,
   output logic [NREGS-1:0] busy_o,
`ifdef WB_BYPASS_EN
   input  logic [IDXW-1:0]  ra_index_i,
   input  logic [31:0]      rvalue_a_i,
   output logic [31:0]      rvalue_a_o,
   input  logic [IDXW-1:0]  rb_index_i,
   input  logic [31:0]      rvalue_b_i,
   output logic [31:0]      rvalue_b_o,
`endif
   output logic [IDXW-1:0]  reg_w_idx_o,
   output logic [31:0]      wdata_o,
   output logic             wen_o,
   output logic [1:0]       wr_scope_o
);

   localparam int PTRW = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
   localparam int CNTW = PTRW + 1;

   // Load FIFO storage (no reset needed: the count defines validity)
   logic [IDXW-1:0] ldq_idx_q   [LDQ_DEPTH];
   logic [31:0]     ldq_data_q  [LDQ_DEPTH];
   logic [1:0]      ldq_scope_q [LDQ_DEPTH];

   logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] cnt_q, cnt_d;

   logic [IDXW-1:0]  idx_q, idx_d;
   logic [31:0]      data_q, data_d;
   logic [1:0]       scope_q, scope_d;
   logic             wen_q, wen_d;
   logic [NREGS-1:0] busy_q, busy_d;

   logic ldq_full, ldq_empty, push, pop, ex_take;

   assign ldq_full   = (cnt_q == CNTW'(LDQ_DEPTH));
   assign ldq_empty  = (cnt_q == '0);
   assign ex_ready_o = !ldq_full;
   assign ld_ready_o = !ldq_full;

   // A full FIFO always wins so loads cannot be starved forever; otherwise ex has priority.
   assign pop     = !ldq_empty && (ldq_full || !ex_valid_i);
   assign ex_take = !pop && ex_valid_i && ex_ready_o;
   assign push    = ld_valid_i && ld_ready_o;

   always_comb begin
      wen_d    = 1'b0;
      idx_d    = idx_q;
      data_d   = data_q;
      scope_d  = scope_q;
      busy_d   = busy_q;
      wr_ptr_d = wr_ptr_q + PTRW'(push);
      rd_ptr_d = rd_ptr_q + PTRW'(pop);
      cnt_d    = cnt_q + CNTW'(push) - CNTW'(pop);
      if (pop) begin
         idx_d   = ldq_idx_q[rd_ptr_q];
         data_d  = ldq_data_q[rd_ptr_q];
         scope_d = ldq_scope_q[rd_ptr_q];
         wen_d   = |ldq_scope_q[rd_ptr_q];  // scope 00 retires silently
         busy_d[ldq_idx_q[rd_ptr_q]] = 1'b0;
      end else if (ex_take) begin
         idx_d   = ex_idx_i;
         data_d  = ex_data_i;
         scope_d = ex_scope_i;
         wen_d   = |ex_scope_i;
         busy_d[ex_idx_i] = 1'b0;
      end
      // Applied after the clear so a same-edge reserve of the retiring register wins.
      if (reserve_i) begin
         busy_d[reserve_idx_i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         scope_q  <= '0;
         wen_q    <= 1'b0;
         busy_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         scope_q  <= scope_d;
         wen_q    <= wen_d;
         busy_q   <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         ldq_idx_q[wr_ptr_q]   <= ld_idx_i;
         ldq_data_q[wr_ptr_q]  <= ld_data_i;
         ldq_scope_q[wr_ptr_q] <= ld_scope_i;
      end
   end

   assign reg_w_idx_o = idx_q;
   assign wdata_o     = data_q;
   assign wr_scope_o  = scope_q;
   assign wen_o       = wen_q;
   assign busy_o      = busy_q;

`ifdef WB_BYPASS_EN
   // Forward the in-flight write half-by-half over the register-file read value.
   function automatic logic [31:0] bypass(input logic [IDXW-1:0] ridx, input logic [31:0] rval);
      logic [31:0] v;
      v = rval;
      if (wen_q && (idx_q == ridx)) begin
         if (scope_q[1]) v[31:16] = data_q[31:16];
         if (scope_q[0]) v[15:0]  = data_q[15:0];
      end
      return v;
   endfunction

   assign rvalue_a_o = bypass(ra_index_i, rvalue_a_i);
   assign rvalue_b_o = bypass(rb_index_i, rvalue_b_i);
`endif

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// tb_reg_wb_ctrl: directed self-checking bench for reg_wb_ctrl.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
//   Expected values are hand-computed constants.
module tb_reg_wb_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid_i, ex_ready_o;
   logic [3:0]  ex_idx_i;
   logic [31:0] ex_data_i;
   logic [1:0]  ex_scope_i;
   logic        ld_valid_i, ld_ready_o;
   logic [3:0]  ld_idx_i;
   logic [31:0] ld_data_i;
   logic [1:0]  ld_scope_i;
   logic        reserve_i;
   logic [3:0]  reserve_idx_i;
   logic [15:0] busy_o;
   logic [3:0]  reg_w_idx_o;
   logic [31:0] wdata_o;
   logic        wen_o;
   logic [1:0]  wr_scope_o;
`ifdef WB_BYPASS_EN
   logic [3:0]  ra_index_i, rb_index_i;
   logic [31:0] rvalue_a_i, rvalue_a_o, rvalue_b_i, rvalue_b_o;
`endif

   int vec_cnt = 0;
   int err_cnt = 0;

   reg_wb_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_idx_i(ex_idx_i),
      .ex_data_i(ex_data_i), .ex_scope_i(ex_scope_i),
      .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_idx_i(ld_idx_i),
      .ld_data_i(ld_data_i), .ld_scope_i(ld_scope_i),
      .reserve_i(reserve_i), .reserve_idx_i(reserve_idx_i), .busy_o(busy_o),
`ifdef WB_BYPASS_EN
      .ra_index_i(ra_index_i), .rvalue_a_i(rvalue_a_i), .rvalue_a_o(rvalue_a_o),
      .rb_index_i(rb_index_i), .rvalue_b_i(rvalue_b_i), .rvalue_b_o(rvalue_b_o),
`endif
      .reg_w_idx_o(reg_w_idx_o), .wdata_o(wdata_o), .wen_o(wen_o), .wr_scope_o(wr_scope_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ex_drive(input logic v, input logic [3:0] i, input logic [31:0] d, input logic [1:0] s);
      ex_valid_i = v; ex_idx_i = i; ex_data_i = d; ex_scope_i = s;
   endtask

   task automatic ld_drive(input logic v, input logic [3:0] i, input logic [31:0] d, input logic [1:0] s);
      ld_valid_i = v; ld_idx_i = i; ld_data_i = d; ld_scope_i = s;
   endtask

   initial begin
      rst_n = 1'b0;
      ex_drive(1'b0, 4'd0, 32'h0, 2'b00);
      ld_drive(1'b0, 4'd0, 32'h0, 2'b00);
      reserve_i = 1'b0; reserve_idx_i = 4'd0;
`ifdef WB_BYPASS_EN
      ra_index_i = 4'd0; rb_index_i = 4'd0; rvalue_a_i = 32'h0; rvalue_b_i = 32'h0;
`endif
      #2;
      chk("rst_wen", wen_o, 0);
      chk("rst_idx", reg_w_idx_o, 0);
      chk("rst_data", wdata_o, 0);
      chk("rst_scope", wr_scope_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_ex_rdy", ex_ready_o, 1);
      chk("rst_ld_rdy", ld_ready_o, 1);
      #10 rst_n = 1'b1;

      // 1: basic ex write, one-cycle pulse
      ex_drive(1'b1, 4'd3, 32'hDEADBEEF, 2'b11);
      step();
      chk("t1_wen", wen_o, 1);
      chk("t1_idx", reg_w_idx_o, 3);
      chk("t1_data", wdata_o, 32'hDEADBEEF);
      chk("t1_scope", wr_scope_o, 2'b11);
      ex_drive(1'b0, 4'd0, 32'h0, 2'b00);
      step();
      chk("t1_wen_off", wen_o, 0);
      chk("t1_data_hold", wdata_o, 32'hDEADBEEF);

      // 2: scoreboard set/clear
      reserve_i = 1'b1; reserve_idx_i = 4'd5;
      step();
      chk("t2_busy5_n", busy_o[5], 1);
      reserve_i = 1'b0;
      step();
      chk("t2_busy5_n1", busy_o[5], 1);
      step();
      chk("t2_busy5_n2", busy_o[5], 1);
      ex_drive(1'b1, 4'd5, 32'h0000_0055, 2'b11);
      step();
      chk("t2_busy5_clr", busy_o[5], 0);
      chk("t2_wen5", wen_o, 1);
      reserve_i = 1'b1; reserve_idx_i = 4'd7;
      ex_drive(1'b0, 4'd0, 32'h0, 2'b00);
      step();
      chk("t2_busy7_set", busy_o, 16'h0080);
      ex_drive(1'b1, 4'd7, 32'h0000_0077, 2'b11);
      step();
      chk("t2_busy7_setwins", busy_o[7], 1);
      chk("t2_idx7", reg_w_idx_o, 7);
      reserve_i = 1'b0;
      step();
      chk("t2_busy7_clr", busy_o[7], 0);

      // 3: fill FIFO under continuous ex traffic
      ex_drive(1'b1, 4'd10, 32'hA0A0_A0A0, 2'b11);
      ld_drive(1'b1, 4'd1, 32'h1111_0001, 2'b11);
      step();
      chk("t3_e1_idx", reg_w_idx_o, 10);
      ld_drive(1'b1, 4'd2, 32'h2222_0002, 2'b11);
      step();
      chk("t3_e2_ldrdy", ld_ready_o, 0);
      chk("t3_e2_exrdy", ex_ready_o, 0);
      ld_drive(1'b0, 4'd0, 32'h0, 2'b00);
      ex_drive(1'b1, 4'd11, 32'hB0B0_B0B0, 2'b11);
      step();
      chk("t3_e3_idx", reg_w_idx_o, 1);
      chk("t3_e3_data", wdata_o, 32'h1111_0001);
      chk("t3_e3_exrdy", ex_ready_o, 1);
      step();
      chk("t3_e4_idx", reg_w_idx_o, 11);
      chk("t3_e4_data", wdata_o, 32'hB0B0_B0B0);
      ex_drive(1'b0, 4'd0, 32'h0, 2'b00);
      step();
      chk("t3_e5_idx", reg_w_idx_o, 2);
      chk("t3_e5_data", wdata_o, 32'h2222_0002);
      chk("t3_e5_wen", wen_o, 1);
      step();
      chk("t3_e6_wen", wen_o, 0);

      // 4: single load with idle ex; then push+pop on one edge
      ld_drive(1'b1, 4'd9, 32'h9999_9999, 2'b11);
      step();
      chk("t4_lat_wen", wen_o, 0);
      ld_drive(1'b0, 4'd0, 32'h0, 2'b00);
      step();
      chk("t4_wen", wen_o, 1);
      chk("t4_idx", reg_w_idx_o, 9);
      ld_drive(1'b1, 4'd12, 32'hC0C0_000C, 2'b11);
      step();
      ld_drive(1'b1, 4'd13, 32'hD0D0_000D, 2'b11);
      step();
      chk("t4_pp_idx", reg_w_idx_o, 12);
      chk("t4_pp_ldrdy", ld_ready_o, 1);
      ld_drive(1'b0, 4'd0, 32'h0, 2'b00);
      step();
      chk("t4_pp2_idx", reg_w_idx_o, 13);
      chk("t4_pp2_data", wdata_o, 32'hD0D0_000D);
      step();
      chk("t4_empty_wen", wen_o, 0);

      // 5: scope 00 retires without write; scope 01 write
      reserve_i = 1'b1; reserve_idx_i = 4'd4;
      step();
      reserve_i = 1'b0;
      chk("t5_busy4_set", busy_o[4], 1);
      ex_drive(1'b1, 4'd4, 32'h4444_4444, 2'b00);
      step();
      chk("t5_wen0", wen_o, 0);
      chk("t5_busy4_clr", busy_o[4], 0);
      ex_drive(1'b1, 4'd8, 32'h1234ABCD, 2'b01);
      step();
      chk("t5_scope01", wr_scope_o, 2'b01);
      chk("t5_data", wdata_o, 32'h1234ABCD);
      chk("t5_wen1", wen_o, 1);

      // 6: async reset with two loads queued
      ex_drive(1'b1, 4'd0, 32'h0000_0077, 2'b11);
      ld_drive(1'b1, 4'd14, 32'hEEEE_000E, 2'b11);
      reserve_i = 1'b1; reserve_idx_i = 4'd1;
      step();
      ld_drive(1'b1, 4'd15, 32'hFFFF_000F, 2'b11);
      step();
      chk("t6_full", ld_ready_o, 0);
      ld_drive(1'b0, 4'd0, 32'h0, 2'b00);
      ex_drive(1'b0, 4'd0, 32'h0, 2'b00);
      reserve_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_wen", wen_o, 0);
      chk("t6_rst_idx", reg_w_idx_o, 0);
      chk("t6_rst_data", wdata_o, 0);
      chk("t6_rst_busy", busy_o, 0);
      chk("t6_rst_ldrdy", ld_ready_o, 1);
      #8 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t6_no_stale_wen", wen_o, 0);
      end

`ifdef WB_BYPASS_EN
      ex_drive(1'b1, 4'd6, 32'hAAAA0000, 2'b10);
      step();
      ex_drive(1'b0, 4'd0, 32'h0, 2'b00);
      ra_index_i = 4'd6; rvalue_a_i = 32'h11112222;
      rb_index_i = 4'd7; rvalue_b_i = 32'h33334444;
      #1;
      chk("byp_a", rvalue_a_o, 32'hAAAA2222);
      chk("byp_b_miss", rvalue_b_o, 32'h33334444);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/reg_wb_ctrl.md
Name: reg_wb_ctrl

Overview:
Writeback controller that drives the single write port of the general-purpose register file (16 x 32-bit, half-word write scopes).
- Merges two result sources into one registered write stream:
  - execute results, on a direct path;
  - memory-load results, through a small FIFO.
- Keeps a per-register pending-write scoreboard that issue logic uses for hazard stalls.

Parameters:
NREGS, 16, number of architectural registers (one busy bit each)
IDXW, 4, register index width (log2 NREGS)
LDQ_DEPTH, 2, load-result FIFO depth (power of 2, >= 2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ex_valid_i  in  1  execute result valid
ex_ready_o  out  1  execute result accepted when valid&ready at clk edge
ex_idx_i  in  IDXW  execute destination register
ex_data_i  in  32  execute result data
ex_scope_i  in  2  write scope (bit1 high half, bit0 low half)
ld_valid_i  in  1  load result valid
ld_ready_o  out  1  load FIFO can accept
ld_idx_i  in  IDXW  load destination register
ld_data_i  in  32  load data
ld_scope_i  in  2  load write scope
reserve_i  in  1  issue stage reserves a destination this cycle
reserve_idx_i  in  IDXW  register being reserved
busy_o  out  NREGS  scoreboard: bit n = write to reg n pending
reg_w_idx_o  out  IDXW  to register file write index
wdata_o  out  32  to register file write data
wen_o  out  1  to register file write enable
wr_scope_o  out  2  to register file write scope

Behaviour:
- Reset (async, any time, including mid-operation):
  - wen_o=0, reg_w_idx_o=0, wdata_o=0, wr_scope_o=0, busy_o=0.
  - Load FIFO emptied; queued entries are discarded.
- All register-file outputs are registered and change only at clk edges.
- ex_ready_o = !ldq_full.
- ld_ready_o = !ldq_full.
- Neither ready depends combinationally on any valid input.
- Per-edge selection, in priority order:
  1. FIFO non-empty AND (FIFO full OR !ex_valid_i) -> pop FIFO head into the outputs. An ex result offered in this cycle is not accepted, because ex_ready_o=0 when the FIFO is full.
  2. Otherwise, ex_valid_i & ex_ready_o -> ex result into the outputs.
  3. Otherwise -> wen_o=0; the other outputs hold their previous values.
- Load handshake: ld_valid_i & ld_ready_o pushes the load into the FIFO. Push and pop may occur on the same edge; the count is unchanged.
- Latency:
  - ex accepted at edge N -> wen_o high during cycle N..N+1 (1 cycle).
  - A load pushed into an empty FIFO at edge N is popped at edge N+1 at the earliest (2 cycles).
- FIFO order is strictly FIFO. Pointers wrap modulo LDQ_DEPTH. Count width is log2(LDQ_DEPTH)+1.
- Scope 2'b00 entries are accepted and popped normally, but produce wen_o=0. They still clear the busy bit.
- Scoreboard:
  - The edge that loads an entry into the outputs clears busy[idx].
  - reserve_i sets busy[reserve_idx_i] on the same edge.
  - Set and clear of the same index on the same edge -> set wins (bit ends 1).
  - Reserving an already-busy register leaves it at 1; there is no counting.
- wen_o is a single-cycle pulse per written entry. Back-to-back writes on consecutive cycles are allowed.

Optional Feature:
WB_BYPASS_EN
- When defined, adds read-bypass ports:
  - ra_index_i (in IDXW), rvalue_a_i (in 32), rvalue_a_o (out 32);
  - rb_index_i (in IDXW), rvalue_b_i (in 32), rvalue_b_o (out 32).
- The bypass is purely combinational.
- If wen_o and reg_w_idx_o == ra_index_i:
  - rvalue_a_o takes wdata_o halves per wr_scope_o;
  - the other half comes from rvalue_a_i.
- Port b is identical.
- When not defined, these ports do not exist and no bypass logic is built.

Test Plan:
1. Reset released, ex_valid_i=1, idx=3, data=32'hDEADBEEF, scope=11 -> next cycle: wen_o=1, reg_w_idx_o=3, wdata_o=DEADBEEF, wr_scope_o=11. The cycle after: wen_o=0.
2. reserve_i idx=5 at edge N; ex write to idx 5 accepted at edge N+3 -> busy_o[5]=1 from N to N+3, 0 after. Reserve 7 and complete 7 on the same edge -> busy_o[7] stays 1.
3. Push 2 loads (idx 1, 2) while ex_valid_i stays high -> FIFO full, ld_ready_o=0 and ex_ready_o=0. Loads written in order 1 then 2. ex is accepted only after the FIFO drops below full.
4. FIFO holds 1 load (idx 9), ex_valid_i=0 -> load written next cycle. Simultaneous push plus pop keeps the count at 1.
5. Entry with scope=00, idx=4, busy[4]=1 -> wen_o stays 0 and busy_o[4] clears. Scope=01, data=32'h1234ABCD -> wr_scope_o=01, wdata_o=1234ABCD.
6. Assert rst_n=0 mid-stream with 2 loads queued -> all outputs 0 immediately. After release no queued load is written. With WB_BYPASS_EN defined: wen_o=1, idx 6, scope 10, wdata 32'hAAAA0000, ra_index_i=6, rvalue_a_i=32'h11112222 -> rvalue_a_o=32'hAAAA2222.
